// File: rtl/load_wb_unit.sv
// Load unit: computes the effective address, issues an aligned 64-bit read,
// extracts and extends the addressed field, and writes it to the register file.
module load_wb_unit #(
    parameter int unsigned CPU_WIDTH      = 64,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [CPU_WIDTH-1:0]      ld_base,
    input  logic [31:0]               ld_imm,
    input  logic [2:0]                ld_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
    input  logic                      ld_flush,
    output logic                      mem_rreq,
    output logic [CPU_WIDTH-1:0]      mem_raddr,
    input  logic                      mem_rgnt,
    input  logic                      mem_rvalid,
    input  logic [CPU_WIDTH-1:0]      mem_rdata,
    output logic                      reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    output logic [CPU_WIDTH-1:0]      reg_wdata,
    output logic                      ld_done,
    output logic                      ld_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_WB
    } state_t;

    state_t                    state;
    logic [CPU_WIDTH-1:0]      ea_q;
    logic [2:0]                funct3_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;

    logic [CPU_WIDTH-1:0] ea_next;
    logic                 bad_access;
    logic [CPU_WIDTH-1:0] shifted;
    logic [CPU_WIDTH-1:0] extended;

    assign ea_next = ld_base + {{(CPU_WIDTH-32){ld_imm[31]}}, ld_imm};

    always_comb begin
        bad_access = 1'b0;
        unique case (ld_funct3)
            3'b001, 3'b101: bad_access = ea_next[0];
            3'b010, 3'b110: bad_access = |ea_next[1:0];
            3'b011:         bad_access = |ea_next[2:0];
            3'b111:         bad_access = 1'b1;
            default:        bad_access = 1'b0;
        endcase
    end

    // Extraction works on the live read data so the extended value can be
    // registered straight into reg_wdata on the capture edge.
    assign shifted = mem_rdata >> {ea_q[2:0], 3'b000};

    always_comb begin
        extended = '0;
        unique case (funct3_q)
            3'b000:  extended = {{(CPU_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  extended = {{(CPU_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b010:  extended = {{(CPU_WIDTH-32){shifted[31]}}, shifted[31:0]};
            3'b011:  extended = mem_rdata;
            3'b100:  extended = {{(CPU_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  extended = {{(CPU_WIDTH-16){1'b0}}, shifted[15:0]};
            3'b110:  extended = {{(CPU_WIDTH-32){1'b0}}, shifted[31:0]};
            default: extended = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ea_q      <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            ld_ready  <= 1'b1;
            mem_rreq  <= 1'b0;
            mem_raddr <= '0;
            reg_wen   <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
            ld_done   <= 1'b0;
            ld_err    <= 1'b0;
        end else begin
            reg_wen <= 1'b0;
            ld_done <= 1'b0;
            ld_err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (ld_valid && ld_ready) begin
                        ea_q     <= ea_next;
                        funct3_q <= ld_funct3;
                        rd_q     <= ld_rd;
                        ld_ready <= 1'b0;
                        if (bad_access) begin
                            state  <= S_ERR;
                            ld_err <= 1'b1;
                        end else begin
                            state     <= S_REQ;
                            mem_rreq  <= 1'b1;
                            mem_raddr <= {ea_next[CPU_WIDTH-1:3], 3'b000};
                        end
                    end
                end
                S_ERR: begin
                    state    <= S_IDLE;
                    ld_ready <= 1'b1;
                end
                S_REQ: begin
                    // A flush coinciding with grant still owes us a response.
                    if (mem_rgnt) begin
                        mem_rreq  <= 1'b0;
                        mem_raddr <= '0;
                        state     <= ld_flush ? S_DRAIN : S_WAIT;
                    end else if (ld_flush) begin
                        mem_rreq  <= 1'b0;
                        mem_raddr <= '0;
                        state     <= S_IDLE;
                        ld_ready  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ld_flush) begin
                        if (mem_rvalid) begin
                            state    <= S_IDLE;
                            ld_ready <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (mem_rvalid) begin
                        state     <= S_WB;
                        reg_wen   <= (rd_q != '0);
                        reg_waddr <= rd_q;
                        reg_wdata <= extended;
                        ld_done   <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (mem_rvalid) begin
                        state    <= S_IDLE;
                        ld_ready <= 1'b1;
                    end
                end
                S_WB: begin
                    state     <= S_IDLE;
                    ld_ready  <= 1'b1;
                    reg_waddr <= '0;
                    reg_wdata <= '0;
                end
                default: begin
                    state    <= S_IDLE;
                    ld_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_wb_unit.sv
// Scoreboard bench for load_wb_unit: expected write-backs and error pulses are
// queued at issue time and checked whenever the unit reports completion.
module tb_load_wb_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [63:0] ld_base = '0;
    logic [31:0] ld_imm = '0;
    logic [2:0]  ld_funct3 = '0;
    logic [4:0]  ld_rd = '0;
    logic        ld_flush = 1'b0;
    logic        mem_rreq;
    logic [63:0] mem_raddr;
    logic        mem_rgnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [63:0] reg_wdata;
    logic        ld_done;
    logic        ld_err;

    typedef struct {
        logic        is_err;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    load_wb_unit #(.CPU_WIDTH(64), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_base(ld_base), .ld_imm(ld_imm), .ld_funct3(ld_funct3), .ld_rd(ld_rd),
        .ld_flush(ld_flush),
        .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_rgnt(mem_rgnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .ld_done(ld_done), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && (ld_done || ld_err || reg_wen)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: done=%0b err=%0b wen=%0b rd=%0d data=%h, required no output",
                         ld_done, ld_err, reg_wen, reg_waddr, reg_wdata);
            end else begin
                mon_e = sb.pop_front();
                if (ld_err !== mon_e.is_err || ld_done !== !mon_e.is_err || reg_wen !== mon_e.wen ||
                    (mon_e.wen && (reg_waddr !== mon_e.rd || reg_wdata !== mon_e.data))) begin
                    fails++;
                    $display("FAIL scoreboard: got err=%0b done=%0b wen=%0b rd=%0d data=%h, required err=%0b wen=%0b rd=%0d data=%h",
                             ld_err, ld_done, reg_wen, reg_waddr, reg_wdata,
                             mon_e.is_err, mon_e.wen, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic issue(input logic [63:0] base, input logic [31:0] imm,
                         input logic [2:0] f3, input logic [4:0] rd);
        tests++;
        if (ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_before_accept: ld_ready=%b, required 1", ld_ready);
        end
        ld_valid  = 1'b1;
        ld_base   = base;
        ld_imm    = imm;
        ld_funct3 = f3;
        ld_rd     = rd;
        @(negedge clk);
        ld_valid  = 1'b0;
    endtask

    task automatic serve(input int gdelay, input int vdelay,
                         input logic [63:0] data, input logic [63:0] addr);
        int cyc = 0;
        while (mem_rreq !== 1'b1 && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (mem_rreq !== 1'b1) begin
            fails++;
            $display("FAIL req_timeout: mem_rreq=%b, required 1", mem_rreq);
            return;
        end
        tests++;
        if (mem_raddr !== addr) begin
            fails++;
            $display("FAIL raddr: got %h, required %h", mem_raddr, addr);
        end
        repeat (gdelay) begin
            @(negedge clk);
            tests++;
            if (mem_rreq !== 1'b1 || mem_raddr !== addr || ld_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold: rreq=%b raddr=%h ready=%b, required 1 %h 0",
                         mem_rreq, mem_raddr, ld_ready, addr);
            end
        end
        mem_rgnt = 1'b1;
        @(negedge clk);
        mem_rgnt = 1'b0;
        repeat (vdelay) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tests++;
        if (ld_ready !== 1'b1 || mem_rreq !== 1'b0 || mem_raddr !== 64'h0 || reg_wen !== 1'b0 ||
            reg_waddr !== 5'd0 || reg_wdata !== 64'h0 || ld_done !== 1'b0 || ld_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ready=%b rreq=%b raddr=%h wen=%b waddr=%0d wdata=%h done=%b err=%b, required 1 and zeros",
                     ld_ready, mem_rreq, mem_raddr, reg_wen, reg_waddr, reg_wdata, ld_done, ld_err);
        end
    endtask

    task automatic test_lb();
        sb.push_back(exp_t'{1'b0, 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FF80});
        issue(64'h1000, 32'hFFFF_FFFF, 3'b000, 5'd3);
        tests++;
        if (mem_rreq !== 1'b1 || mem_raddr !== 64'hFF8) begin
            fails++;
            $display("FAIL lb_req: rreq=%b raddr=%h, required 1 0000000000000ff8", mem_rreq, mem_raddr);
        end
        mem_rgnt = 1'b1;
        @(negedge clk);
        mem_rgnt   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h8000_0000_0000_0000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tests++;
        if (reg_wen !== 1'b1 || ld_done !== 1'b1) begin
            fails++;
            $display("FAIL lb_latency: wen=%b done=%b three cycles after accept, required 1 1", reg_wen, ld_done);
        end
        @(negedge clk);
        tests++;
        if (ld_ready !== 1'b1 || reg_wen !== 1'b0 || ld_done !== 1'b0) begin
            fails++;
            $display("FAIL lb_one_cycle: ready=%b wen=%b done=%b, required 1 0 0", ld_ready, reg_wen, ld_done);
        end
    endtask

    typedef struct {
        logic [63:0] base;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [63:0] raddr;
        logic [63:0] exp;
    } ext_case_t;

    task automatic test_extract();
        ext_case_t tbl[9];
        tbl[0] = '{64'h2000, 32'd4,          3'b101, 64'h2000, 64'h0000_0000_0000_CDEF};
        tbl[1] = '{64'h2000, 32'd4,          3'b110, 64'h2000, 64'h0000_0000_89AB_CDEF};
        tbl[2] = '{64'h2000, 32'd0,          3'b011, 64'h2000, 64'h89AB_CDEF_1234_5678};
        tbl[3] = '{64'h2000, 32'd4,          3'b010, 64'h2000, 64'hFFFF_FFFF_89AB_CDEF};
        tbl[4] = '{64'h2008, 32'hFFFF_FFFF,  3'b000, 64'h2000, 64'hFFFF_FFFF_FFFF_FF89};
        tbl[5] = '{64'h2000, 32'd5,          3'b100, 64'h2000, 64'h0000_0000_0000_00CD};
        tbl[6] = '{64'h2000, 32'd2,          3'b001, 64'h2000, 64'h0000_0000_0000_1234};
        tbl[7] = '{64'h2000, 32'd6,          3'b001, 64'h2000, 64'hFFFF_FFFF_FFFF_89AB};
        tbl[8] = '{64'h0,    32'hFFFF_FFF8,  3'b011, 64'hFFFF_FFFF_FFFF_FFF8, 64'h89AB_CDEF_1234_5678};
        for (int i = 0; i < 9; i++) begin
            sb.push_back(exp_t'{1'b0, 1'b1, 5'(i + 1), tbl[i].exp});
            issue(tbl[i].base, tbl[i].imm, tbl[i].f3, 5'(i + 1));
            serve(0, i % 3, 64'h89AB_CDEF_1234_5678, tbl[i].raddr);
        end
    endtask

    task automatic test_err();
        logic [31:0] imms[6];
        logic [2:0]  f3s[6];
        imms = '{32'd1, 32'd2, 32'd4, 32'd0, 32'd3, 32'd6};
        f3s  = '{3'b001, 3'b010, 3'b011, 3'b111, 3'b101, 3'b110};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(exp_t'{1'b1, 1'b0, 5'd0, 64'h0});
            issue(64'h1000, imms[i], f3s[i], 5'd4);
            tests++;
            if (mem_rreq !== 1'b0 || ld_ready !== 1'b0) begin
                fails++;
                $display("FAIL err_state_%0d: rreq=%b ready=%b, required 0 0", i, mem_rreq, ld_ready);
            end
            @(negedge clk);
            tests++;
            if (mem_rreq !== 1'b0 || ld_ready !== 1'b1) begin
                fails++;
                $display("FAIL err_return_%0d: rreq=%b ready=%b, required 0 1", i, mem_rreq, ld_ready);
            end
        end
    endtask

    task automatic test_stall();
        sb.push_back(exp_t'{1'b0, 1'b1, 5'd7, 64'h0123_4567_89AB_CDEF});
        issue(64'h3000, 32'd0, 3'b011, 5'd7);
        serve(4, 1, 64'h0123_4567_89AB_CDEF, 64'h3000);
    endtask

    task automatic test_flush();
        issue(64'h4000, 32'd0, 3'b011, 5'd8);
        ld_flush = 1'b1;
        @(negedge clk);
        ld_flush = 1'b0;
        tests++;
        if (ld_ready !== 1'b1 || mem_rreq !== 1'b0) begin
            fails++;
            $display("FAIL flush_req: ready=%b rreq=%b, required 1 0", ld_ready, mem_rreq);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);

        issue(64'h4000, 32'd0, 3'b011, 5'd9);
        mem_rgnt = 1'b1;
        @(negedge clk);
        mem_rgnt = 1'b0;
        ld_flush = 1'b1;
        @(negedge clk);
        ld_flush = 1'b0;
        @(negedge clk);
        tests++;
        if (ld_ready !== 1'b0) begin
            fails++;
            $display("FAIL drain_busy: ready=%b, required 0", ld_ready);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hBEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        tests++;
        if (ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL drain_done: ready=%b, required 1", ld_ready);
        end

        sb.push_back(exp_t'{1'b0, 1'b1, 5'd10, 64'h0000_0000_0000_0055});
        issue(64'h4003, 32'd0, 3'b100, 5'd10);
        serve(0, 0, 64'h0000_0000_5500_0000, 64'h4000);
    endtask

    task automatic test_rd0_and_reset();
        sb.push_back(exp_t'{1'b0, 1'b0, 5'd0, 64'h0});
        issue(64'h10, 32'd0, 3'b010, 5'd0);
        serve(0, 0, 64'h1111_2222_3333_4444, 64'h10);

        issue(64'h5000, 32'd0, 3'b011, 5'd9);
        mem_rgnt = 1'b1;
        @(negedge clk);
        mem_rgnt = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (ld_ready !== 1'b1 || mem_rreq !== 1'b0 || mem_raddr !== 64'h0 || reg_wen !== 1'b0 || ld_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_wait: ready=%b rreq=%b raddr=%h wen=%b done=%b, required 1 0 0 0 0",
                     ld_ready, mem_rreq, mem_raddr, reg_wen, ld_done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hCAFE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_recover: ready=%b, required 1", ld_ready);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_lb();
        test_extract();
        test_err();
        test_stall();
        test_flush();
        test_rd0_and_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
